// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, opcode encodings and the queued command payload.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OPC_W  = 3;

  typedef enum logic [OPC_W-1:0] {
    OPC_ADD = 3'b000,
    OPC_SUB = 3'b001,
    OPC_AND = 3'b010,
    OPC_OR  = 3'b011,
    OPC_XOR = 3'b100,
    OPC_SHL = 3'b101,
    OPC_SHR = 3'b110,
    OPC_SLT = 3'b111
  } opc_e;

  // Opcode is carried as raw bits so every encoding passes through untouched.
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command storage for alu_cmd_queue: DEPTH-entry circular buffer with wrapping
// pointers and an occupancy counter. Storage is not reset; only control state is.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  cmd_t          wdata,
  output cmd_t          rdata,
  output logic [LW-1:0] level
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          push_ok;
  logic          pop_ok;
  cmd_t          mem [DEPTH];

  // Local guards keep the counter inside 0..DEPTH whatever the caller does.
  assign push_ok = push && (count != LW'(DEPTH));
  assign pop_ok  = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign level = count;

endmodule

// File: rtl/alu_cmd_queue.sv
// Valid/ready command queue in front of the ALU. Define ALU_CMD_BYPASS_EN to let a
// command reach the ALU in the same cycle when the queue is empty and the ALU is ready.
module alu_cmd_queue
  import alu_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [OPC_W-1:0]  in_opcode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [OPC_W-1:0]  opcode,
  output logic [LW-1:0]     level
);

  cmd_t in_cmd;
  cmd_t head;
  cmd_t out_cmd;
  logic empty;
  logic bypass;
  logic push;
  logic pop;

  assign in_cmd = '{opcode: in_opcode, a: in_a, b: in_b};
  assign empty  = (level == '0);

  // in_ready depends on the registered level only, never on out_ready.
  assign in_ready = (level != LW'(DEPTH));

`ifdef ALU_CMD_BYPASS_EN
  assign bypass = empty && in_valid && out_ready;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed command goes straight to the ALU and is never stored.
  assign push      = in_valid && in_ready && !bypass;
  assign pop       = !empty && out_ready;
  assign out_valid = !empty || bypass;

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (in_cmd),
    .rdata (head),
    .level (level)
  );

  // Head entry when occupied, live input while bypassing, zeros otherwise.
  always_comb begin
    out_cmd = '0;
    if (!empty) begin
      out_cmd = head;
    end else if (bypass) begin
      out_cmd = in_cmd;
    end
  end

  assign a      = out_cmd.a;
  assign b      = out_cmd.b;
  assign opcode = out_cmd.opcode;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Self-checking bench for alu_cmd_queue: queue-based reference model checked every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_alu_cmd_queue;
  import alu_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_a = '0;
  logic [7:0]    in_b = '0;
  logic [2:0]    in_opcode = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    a;
  logic [7:0]    b;
  logic [2:0]    opcode;
  logic [LW-1:0] level;

  int n_cmp = 0;
  int n_bad = 0;

  logic [18:0] q[$];
  logic        m_byp;
  logic        m_pop;
  logic        m_push;
  logic [18:0] e_cmd;

  always #5 clk = ~clk;

  alu_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_opcode (in_opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .level     (level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic byp_now();
`ifdef ALU_CMD_BYPASS_EN
    return (q.size() == 0) && in_valid && out_ready;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: a plain queue of {opcode,a,b}.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      m_byp  = byp_now();
      m_pop  = (q.size() != 0) && out_ready;
      m_push = in_valid && (q.size() != DEPTH) && !m_byp;
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back({in_opcode, in_a, in_b});
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (q.size() != 0) e_cmd = q[0];
    else if (byp_now()) e_cmd = {in_opcode, in_a, in_b};
    else e_cmd = '0;
    chk("model_in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    chk("model_level", 32'(level), 32'(q.size()));
    chk("model_out_valid", 32'(out_valid), 32'((q.size() != 0) || byp_now()));
    chk("model_cmd", 32'({opcode, a, b}), 32'(e_cmd));
  end

  // Apply inputs for one cycle; returns 1 time unit after the rising edge.
  task automatic cyc(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                     input logic [2:0] op, input logic ordy);
    in_valid  = v;
    in_a      = ia;
    in_b      = ib;
    in_opcode = op;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", 32'(level), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    rst_n = 1'b1;

    // First push right after reset
    cyc(1'b1, 8'h12, 8'h34, OPC_ADD, 1'b0);
    chk("p1_out_valid", 32'(out_valid), 1);
    chk("p1_a", 32'(a), 32'h12);
    chk("p1_b", 32'(b), 32'h34);
    chk("p1_opcode", 32'(opcode), 0);
    chk("p1_level", 32'(level), 1);
    cyc(1'b0, 8'h00, 8'h00, OPC_ADD, 1'b1);
    chk("p1_drained", 32'(level), 0);

    // Fill to full; fifth command held until a pop frees a slot
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(i + 1), 8'(i + 8'h10), 3'(i + 2), 1'b0);
    chk("full_level", 32'(level), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    cyc(1'b1, 8'hFF, 8'h01, OPC_SUB, 1'b0);
    chk("full_hold_level", 32'(level), 4);
    cyc(1'b1, 8'hFF, 8'h01, OPC_SUB, 1'b1);
    chk("full_pop_level", 32'(level), 3);
    chk("full_pop_head", 32'(a), 32'h02);
    cyc(1'b1, 8'hFF, 8'h01, OPC_SUB, 1'b0);
    chk("fifth_accept_level", 32'(level), 4);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 8'h00, OPC_ADD, 1'b1);
    chk("fifth_head_a", 32'(a), 32'hFF);
    chk("fifth_head_b", 32'(b), 32'h01);
    chk("fifth_head_op", 32'(opcode), 32'b001);
    cyc(1'b0, 8'h00, 8'h00, OPC_ADD, 1'b1);

    // Steady push+pop at level 2, pointers wrap several times
    cyc(1'b1, 8'h40, 8'h00, OPC_OR, 1'b0);
    cyc(1'b1, 8'h41, 8'h00, OPC_OR, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h42 + i), 8'(i), OPC_SHL, 1'b1);
    chk("stream_level", 32'(level), 2);
    chk("stream_head", 32'(a), 32'h4A);
    cyc(1'b0, 8'h00, 8'h00, OPC_ADD, 1'b1);
    cyc(1'b0, 8'h00, 8'h00, OPC_ADD, 1'b1);

    // Mid-cycle asynchronous reset discards queued commands
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h20 + i), 8'h00, OPC_AND, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_level", 32'(level), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_cmd", 32'({opcode, a, b}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b1, 8'hAA, 8'h55, OPC_XOR, 1'b0);
    chk("post_rst_a", 32'(a), 32'hAA);
    chk("post_rst_b", 32'(b), 32'h55);
    chk("post_rst_op", 32'(opcode), 32'b100);
    cyc(1'b1, 8'h01, 8'h02, OPC_ADD, 1'b0);
    chk("stable_head", 32'(a), 32'hAA);
    chk("stable_level", 32'(level), 2);
    cyc(1'b0, 8'h00, 8'h00, OPC_ADD, 1'b1);
    cyc(1'b0, 8'h00, 8'h00, OPC_ADD, 1'b1);

    // Empty queue with consumer ready: bypass vs one-cycle latency
    in_valid  = 1'b1;
    in_a      = 8'h03;
    in_b      = 8'h07;
    in_opcode = OPC_SLT;
    out_ready = 1'b1;
    #1;
`ifdef ALU_CMD_BYPASS_EN
    chk("byp_same_valid", 32'(out_valid), 1);
    chk("byp_same_op", 32'(opcode), 32'b111);
    chk("byp_same_a", 32'(a), 32'h03);
    chk("byp_same_level", 32'(level), 0);
`else
    chk("nobyp_same_valid", 32'(out_valid), 0);
`endif
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
`ifdef ALU_CMD_BYPASS_EN
    chk("byp_next_level", 32'(level), 0);
`else
    chk("nobyp_next_valid", 32'(out_valid), 1);
    chk("nobyp_next_a", 32'(a), 32'h03);
    chk("nobyp_next_level", 32'(level), 1);
`endif
    cyc(1'b0, 8'h00, 8'h00, OPC_ADD, 1'b1);

    // Mixed traffic, checked by the model only
    for (int i = 0; i < 80; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
          3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0));
    end
    cyc(1'b0, 8'h00, 8'h00, OPC_ADD, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
